// File: rtl/row_clear_engine.sv
// Row clear engine: scans a locked board bottom-up one row per clock, removes full
// rows by shifting everything above them down, and reports the compacted board and count.
module row_clear_engine #(
    parameter int BOARD_W = 16,
    parameter int BOARD_H = 16,
    parameter int CNT_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BOARD_W*BOARD_H-1:0] board_in,
    output logic                       busy,
    output logic                       done,
    output logic [BOARD_W*BOARD_H-1:0] board_out,
    output logic [CNT_W-1:0]           rows_cleared
);

    localparam int RW = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                       state;
    logic [BOARD_W*BOARD_H-1:0]   work;
    logic [BOARD_W*BOARD_H-1:0]   shifted;
    logic [RW-1:0]                r;
    logic [CNT_W-1:0]             count;
    logic                         row_full;

    always_comb begin
        row_full = &work[r*BOARD_W +: BOARD_W];
    end

    // Rows 1..r drop by one; row 0 refills empty; rows below r are untouched.
    always_comb begin
        shifted = '0;
        for (int unsigned y = 1; y < BOARD_H; y++) begin
            if (y <= 32'(r))
                shifted[y*BOARD_W +: BOARD_W] = work[(y-1)*BOARD_W +: BOARD_W];
            else
                shifted[y*BOARD_W +: BOARD_W] = work[y*BOARD_W +: BOARD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            work         <= '0;
            r            <= '0;
            count        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            board_out    <= '0;
            rows_cleared <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= board_in;
                        r     <= RW'(BOARD_H - 1);
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        // r holds so the row that slid into this index is re-examined
                        work  <= shifted;
                        count <= count + CNT_W'(1);
                    end else if (r != '0) begin
                        r <= r - RW'(1);
                    end else begin
                        board_out    <= work;
                        rows_cleared <= count;
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/row_clear_engine.md
Name: row_clear_engine

Overview:
- Downstream of the game top level: takes the locked board snapshot after a block sticks, finds full rows, collapses the rows above each one downward, and returns the compacted board plus the number of rows cleared.
- The count feeds the score logic.
- Iterative, one row evaluation per clock, so no wide single-cycle combinational loop over the whole board.

Parameters:
- BOARD_W, 16, board width in cells (`BOARD_BLOCK_W).
- BOARD_H, 16, board height in cells (`BOARD_BLOCK_H).
- CNT_W, 5, width of rows_cleared; must hold BOARD_H.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low (rst=0 resets on the next rising clk edge).
- start  input  1  single-cycle request; sampled only in IDLE.
- board_in  input  BOARD_W*BOARD_H  board snapshot. Cell (x,y) is bit x+BOARD_W*y; y=0 is the top row; 1 means occupied.
- busy  output  1  high from the cycle after start is accepted until done deasserts.
- done  output  1  one-cycle pulse; board_out and rows_cleared are valid.
- board_out  output  BOARD_W*BOARD_H  compacted board; held until the next done.
- rows_cleared  output  CNT_W  full rows removed by the last operation; held until the next done.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, board_out=0, rows_cleared=0, FSM=IDLE, internal work board=0, row pointer r=0, count=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - If start=1: work<=board_in, r<=BOARD_H-1, count<=0, busy<=1, go to SCAN.
  - Otherwise hold all state.
- SCAN (one edge per evaluation), examining row r of work:
  - Row full (all BOARD_W bits 1):
    - Every row y in 1..r takes row y-1, and row 0 becomes all zeros, in the same edge.
    - count<=count+1; r unchanged, so the same index is re-examined next edge.
  - Row not full, r>0: r<=r-1.
  - Row not full, r==0:
    - board_out<=work, rows_cleared<=count, done<=1, busy stays 1.
    - Go to DONE.
- DONE:
  - Next edge: done<=0, busy<=0, go to IDLE.
  - start is ignored while in DONE.
- Latency: with k full rows, done is high in the cycle starting BOARD_H+k rising edges after the edge that accepted start.
  - Minimum latency is BOARD_H (k=0).
  - Maximum latency is 2*BOARD_H (all rows full).
- start while busy (SCAN or DONE) is ignored. Changes on board_in after acceptance have no effect.
- Row 0 full: it is cleared, r stays 0, the next edge sees an empty row, and the FSM goes to DONE.
- Adjacent full rows: each is removed in its own edge. Rows shifted into index r are re-checked, so stacked full rows are all removed.
- count never exceeds BOARD_H; CNT_W must be at least clog2(BOARD_H+1).
- Reset at any time, including mid-SCAN or in DONE:
  - Operation aborts and all outputs return to reset values on that edge.
  - No done pulse is produced for the aborted operation.
- Cell order within a row is preserved; only whole rows move.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> busy=0, done=0, board_out=0, rows_cleared=0. No operation starts while rst=0.
- No full rows: board_in has bits 43, 44, 57 set; pulse start -> done high exactly 16 edges after acceptance, board_out==board_in, rows_cleared=0, busy falls one cycle after done.
- Single clear: bits 240..255 (row 15) plus bit 226 (x=2, y=14); start -> done at 17 edges, rows_cleared=1, board_out has only bit 242 set.
- Split clear: rows 15 and 13 full, bit 225 (x=1, y=14) set; start -> done at 18 edges, rows_cleared=2, board_out has only bit 241 set.
- Full board: board_in all ones; start -> done at 32 edges, rows_cleared=16, board_out=0.
- Abuse:
  - Pulse start with a different board_in 3 cycles into SCAN -> ignored; result matches the first snapshot.
  - Drive rst=0 for one cycle mid-SCAN -> busy=0 next edge and no done pulse.
  - A new start afterwards completes normally.
